// File: rtl/rc4_crack_pkg.sv
// rc4_crack_pkg: shared state encoding and plaintext character rules for the RC4 key-search core
package rc4_crack_pkg;
  typedef enum logic [4:0] {
    IDLE, INIT,
    KSA_RD_I, KSA_WT_I, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J,
    PRGA_RD_I, PRGA_WT_I, PRGA_RD_J, PRGA_WT_J, PRGA_WR_I, PRGA_WR_J,
    PRGA_RD_F, PRGA_WT_F, PRGA_WR_D,
    NEXT_KEY, FOUND
  } state_t;
  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;
  function automatic logic is_valid_char(input logic [7:0] c);
    return (c >= CHAR_LO && c <= CHAR_HI) || c == CHAR_SP;
  endfunction
endpackage

// File: rtl/rc4_crack_core_p_keyseq.sv
// rc4_key_sequencer: candidate key register, loads CORE_ID and steps by NUM_CORES
module rc4_key_sequencer
  import rc4_crack_pkg::*;
#(
  parameter int KW        = 24,
  parameter int CORE_ID   = 0,
  parameter int NUM_CORES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  output logic [KW-1:0] key,
  output logic          last
);
  logic [KW-1:0] key_q, key_d;
  logic [KW:0]   next_w;
  // next candidate is one bit wider so a carry out marks the end of this core's key space
  always_comb begin
    next_w = {1'b0, key_q} + (KW+1)'(NUM_CORES);
    last   = next_w[KW];
    key_d  = load ? KW'(CORE_ID) : step ? next_w[KW-1:0] : key_q;
  end
  // key register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_q <= '0;
    else      key_q <= key_d;
  end
  assign key = key_q;
endmodule

// File: rtl/rc4_crack_core_p.sv
// rc4_crack_core_p: RC4 key-search core; one sequencer runs init, KSA and PRGA decrypt per candidate key.
// Per-key cycle cost: INIT 256, KSA 256 x 6 = 1536, PRGA 9 per byte decrypted (at most 9 x MSG_LEN),
// NEXT_KEY 1. Reads take two cycles (address register, then RAM register) so each RD state is followed
// by a WT state and the data is used in the state after WT.
module rc4_crack_core_p
  import rc4_crack_pkg::*;
#(
  parameter  int KEY_BYTES = 3,
  parameter  int MSG_LEN   = 32,
  parameter  int CORE_ID   = 0,
  parameter  int NUM_CORES = 1,
  localparam int KW        = 8 * KEY_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    s_addr,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    s_q,
  output logic [7:0]    e_addr,
  input  logic [7:0]    e_q,
  output logic [7:0]    d_addr,
  output logic [7:0]    d_data,
  output logic          d_wren,
  output logic          busy,
  output logic          found,
  output logic          exhausted,
  output logic [KW-1:0] secret_key
);
  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, si_q, si_d, sj_q, sj_d;
  logic [7:0] s_addr_q, s_addr_d, s_data_q, s_data_d, e_addr_q, e_addr_d;
  logic [7:0] d_addr_q, d_addr_d, d_data_q, d_data_d;
  logic       s_wren_q, s_wren_d, d_wren_q, d_wren_d;
  logic       busy_q, busy_d, found_q, found_d, exhausted_q, exhausted_d;
  logic       key_load, key_step, key_last;
  logic [7:0] kbyte, p;
  logic [KW-1:0] key_w;

  rc4_key_sequencer #(.KW(KW), .CORE_ID(CORE_ID), .NUM_CORES(NUM_CORES)) u_keyseq (
    .clk(clk), .rst(rst), .load(key_load), .step(key_step), .key(key_w), .last(key_last)
  );

  // sequencer: next state, S/E/D port requests and status flags
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    s_addr_d    = s_addr_q;
    s_data_d    = s_data_q;
    s_wren_d    = 1'b0;
    e_addr_d    = e_addr_q;
    d_addr_d    = d_addr_q;
    d_data_d    = d_data_q;
    d_wren_d    = 1'b0;
    busy_d      = busy_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    key_load    = 1'b0;
    key_step    = 1'b0;
    kbyte       = 8'(key_w >> (8 * (KEY_BYTES - 1 - int'(i_q) % KEY_BYTES)));
    p           = s_q ^ e_q;
    case (state_q)
      IDLE: if (start) begin
        found_d     = 1'b0;
        exhausted_d = 1'b0;
        busy_d      = 1'b1;
        key_load    = 1'b1;
        i_d         = '0;
        j_d         = '0;
        k_d         = '0;
        state_d     = INIT;
      end
      INIT: begin
        s_addr_d = i_q;
        s_data_d = i_q;
        s_wren_d = 1'b1;
        i_d      = i_q + 8'd1;
        state_d  = i_q == 8'hFF ? KSA_RD_I : INIT;
      end
      KSA_RD_I: begin
        s_addr_d = i_q;
        state_d  = KSA_WT_I;
      end
      KSA_WT_I: state_d = KSA_RD_J;
      KSA_RD_J: begin
        si_d     = s_q;
        j_d      = j_q + s_q + kbyte;
        s_addr_d = j_d;
        state_d  = KSA_WT_J;
      end
      KSA_WT_J: state_d = KSA_WR_I;
      KSA_WR_I, PRGA_WR_I: begin
        sj_d     = s_q;
        s_addr_d = i_q;
        s_data_d = s_q;
        s_wren_d = 1'b1;
        state_d  = state_q == KSA_WR_I ? KSA_WR_J : PRGA_WR_J;
      end
      KSA_WR_J: begin
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
        i_d      = i_q + 8'd1;
        j_d      = i_q == 8'hFF ? 8'd0 : j_q;
        k_d      = '0;
        state_d  = i_q == 8'hFF ? PRGA_RD_I : KSA_RD_I;
      end
      PRGA_RD_I: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_d;
        state_d  = PRGA_WT_I;
      end
      PRGA_WT_I: state_d = PRGA_RD_J;
      PRGA_RD_J: begin
        si_d     = s_q;
        j_d      = j_q + s_q;
        s_addr_d = j_d;
        state_d  = PRGA_WT_J;
      end
      PRGA_WT_J: state_d = PRGA_WR_I;
      PRGA_WR_J: begin
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
        state_d  = PRGA_RD_F;
      end
      PRGA_RD_F: begin
        s_addr_d = si_q + sj_q;
        e_addr_d = k_q;
        state_d  = PRGA_WT_F;
      end
      PRGA_WT_F: state_d = PRGA_WR_D;
      PRGA_WR_D: begin
        d_addr_d = k_q;
        d_data_d = p;
        d_wren_d = 1'b1;
        k_d      = k_q + 8'd1;
        state_d  = !is_valid_char(p) ? NEXT_KEY : k_q == 8'(MSG_LEN - 1) ? FOUND : PRGA_RD_I;
      end
      NEXT_KEY: begin
        i_d         = '0;
        j_d         = '0;
        exhausted_d = key_last;
        busy_d      = !key_last;
        key_step    = !key_last;
        state_d     = key_last ? IDLE : INIT;
      end
      FOUND: begin
        found_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort drops any pending write and parks the core, but a located key still completes
    if (abort && state_q != IDLE && state_q != FOUND && state_d != FOUND) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      s_wren_d    = 1'b0;
      d_wren_d    = 1'b0;
      key_step    = 1'b0;
      exhausted_d = exhausted_q;
    end
  end

  // state and registered memory-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      s_addr_q    <= '0;
      s_data_q    <= '0;
      s_wren_q    <= 1'b0;
      e_addr_q    <= '0;
      d_addr_q    <= '0;
      d_data_q    <= '0;
      d_wren_q    <= 1'b0;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      s_addr_q    <= s_addr_d;
      s_data_q    <= s_data_d;
      s_wren_q    <= s_wren_d;
      e_addr_q    <= e_addr_d;
      d_addr_q    <= d_addr_d;
      d_data_q    <= d_data_d;
      d_wren_q    <= d_wren_d;
      busy_q      <= busy_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
    end
  end

  assign s_addr     = s_addr_q;
  assign s_data     = s_data_q;
  assign s_wren     = s_wren_q;
  assign e_addr     = e_addr_q;
  assign d_addr     = d_addr_q;
  assign d_data     = d_data_q;
  assign d_wren     = d_wren_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign secret_key = key_w;
endmodule
